// File: rtl/hirose_pkg.sv
// Shared types and constants for the Hirose hash arbiter slice.
package hirose_pkg;

  localparam int BLOCK_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin selector; on a tie the requester not served last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/hirose_hash_arbiter.sv
// Shares one Hirose-PRESENT compression core between two requesters,
// feeding each job's message through the core one 16-bit block at a time.
module hirose_hash_arbiter
  import hirose_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int MSG_WIDTH  = 16 * NUM_BLOCKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [MSG_WIDTH-1:0] msg0,
  input  logic [MSG_WIDTH-1:0] msg1,
  input  logic [63:0]          c,
  output logic [1:0]           grant,
  output logic [1:0]           done,
  output logic [127:0]         digest,
  output logic                 busy,
  output logic                 core_rst,
  output logic [63:0]          core_c,
  output logic [15:0]          core_plaintext,
  output logic [63:0]          core_prev_left,
  output logic [63:0]          core_prev_right,
  input  logic                 core_end,
  input  logic [127:0]         core_hash
);

  localparam int CW = $clog2(NUM_BLOCKS + 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_grant;
  logic                   r_last;
  logic [MSG_WIDTH-1:0]   r_msg;
  logic [63:0]            r_hLeft;
  logic [63:0]            r_hRight;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          w_countNext;
  logic                   w_lastBlock;
  logic [127:0]           r_digest;
  logic [1:0]             r_done;
  logic [1:0]             w_arbGrant;

  rr_arbiter2 u_arb (
    .req   (req),
    .last  (r_last),
    .grant (w_arbGrant)
  );

  assign w_countNext = r_count + CW'(1);
  assign w_lastBlock = (w_countNext == CW'(NUM_BLOCKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (|req) w_next = S_LOAD;
      S_LOAD:   w_next = S_START;
      S_START:  w_next = S_WAIT;
      S_WAIT:   if (core_end) w_next = S_UPDATE;
      S_UPDATE: w_next = w_lastBlock ? S_DONE : S_START;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // r_last resets to 1 so that the first tie goes to requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_msg    <= '0;
      r_hLeft  <= '0;
      r_hRight <= '0;
      r_count  <= '0;
      r_digest <= '0;
      r_done   <= 2'b00;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant <= w_arbGrant;
            r_last  <= w_arbGrant[1];
          end
        end
        S_LOAD: begin
          r_msg    <= r_grant[1] ? msg1 : msg0;
          r_hLeft  <= '0;
          r_hRight <= '0;
          r_count  <= '0;
        end
        S_WAIT: begin
          if (core_end) begin
            r_hLeft  <= core_hash[127:64];
            r_hRight <= core_hash[63:0];
          end
        end
        // Shifting the latched message keeps the current block in the low bits.
        S_UPDATE: begin
          r_count <= w_countNext;
          r_msg   <= r_msg >> BLOCK_WIDTH;
          if (w_lastBlock) begin
            r_digest <= {r_hLeft, r_hRight};
            r_done   <= r_grant;
          end
        end
        S_DONE: begin
          r_grant <= 2'b00;
        end
        default: begin
        end
      endcase
    end
  end

  assign grant           = r_grant;
  assign done            = r_done;
  assign digest          = r_digest;
  assign busy            = (r_state != S_IDLE);
  assign core_rst        = (r_state != S_WAIT);
  assign core_c          = c;
  assign core_plaintext  = r_msg[BLOCK_WIDTH-1:0];
  assign core_prev_left  = r_hLeft;
  assign core_prev_right = r_hRight;

endmodule

// File: tb/tb_hirose_hash_arbiter.sv
// Directed bench for hirose_hash_arbiter with a fixed-latency (L=3) core model.
module tb_hirose_hash_arbiter;

  logic         clk;
  logic         rst;
  logic [1:0]   req;
  logic [63:0]  msg0;
  logic [63:0]  msg1;
  logic [63:0]  c;
  logic [1:0]   grant;
  logic [1:0]   done;
  logic [127:0] digest;
  logic         busy;
  logic         core_rst;
  logic [63:0]  core_c;
  logic [15:0]  core_plaintext;
  logic [63:0]  core_prev_left;
  logic [63:0]  core_prev_right;
  logic         core_end;
  logic [127:0] core_hash;

  logic [1:0]   coreCnt;
  logic         spurEnd;
  int           errors;
  int           checks;

  localparam logic [63:0]  MSG0_VEC = 64'h0004_0003_0002_0001;
  localparam logic [63:0]  MSG1_VEC = 64'h0010_0020_0030_0040;
  localparam logic [127:0] DIG0     = {64'h0000_0000_0000_000A, 64'h0000_0000_0000_0004};
  localparam logic [127:0] DIG1     = {64'h0000_0000_0000_00A0, 64'h0000_0000_0000_0004};

  hirose_hash_arbiter #(.NUM_BLOCKS(4), .MSG_WIDTH(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .msg0            (msg0),
    .msg1            (msg1),
    .c               (c),
    .grant           (grant),
    .done            (done),
    .digest          (digest),
    .busy            (busy),
    .core_rst        (core_rst),
    .core_c          (core_c),
    .core_plaintext  (core_plaintext),
    .core_prev_left  (core_prev_left),
    .core_prev_right (core_prev_right),
    .core_end        (core_end),
    .core_hash       (core_hash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: core_end three cycles after the last core_rst cycle.
  always @(posedge clk) begin
    if (core_rst) coreCnt <= 2'd0;
    else          coreCnt <= coreCnt + 2'd1;
  end
  assign core_end  = (!core_rst && coreCnt == 2'd2) || (spurEnd && core_rst);
  assign core_hash = {core_prev_left + {48'b0, core_plaintext}, core_prev_right + 64'd1};

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one job from request to done, then sets req to reqAfter.
  task automatic applyStimulus(input logic [1:0] expGrant, input logic [127:0] expDigest,
                               input logic [1:0] reqAfter, input int changeAt, input string tag);
    int cyc;
    bit overlap;
    cyc = 0;
    while (grant == 2'b00 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " grant latency"}, 128'(cyc), 128'(1));
    checkOutput({tag, " grant"}, 128'(grant), 128'(expGrant));
    cyc = 0;
    overlap = 1'b0;
    while (done == 2'b00 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!$onehot0(grant)) overlap = 1'b1;
      if (cyc == changeAt) msg0 = '1;
    end
    checkOutput({tag, " done latency"}, 128'(cyc), 128'(21));
    checkOutput({tag, " done"}, 128'(done), 128'(expGrant));
    checkOutput({tag, " digest"}, digest, expDigest);
    checkOutput({tag, " grant overlap"}, 128'(overlap), 128'(0));
    req = reqAfter;
    @(negedge clk);
    checkOutput({tag, " done cleared"}, 128'(done), 128'(0));
    checkOutput({tag, " grant cleared"}, 128'(grant), 128'(0));
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    req     = 2'b00;
    msg0    = MSG0_VEC;
    msg1    = MSG1_VEC;
    c       = 64'h0123_4567_89AB_CDEF;
    spurEnd = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset grant", 128'(grant), 128'(0));
    checkOutput("reset done", 128'(done), 128'(0));
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset digest", digest, 128'(0));
    checkOutput("reset core_rst", 128'(core_rst), 128'(1));
    checkOutput("core_c passthrough", 128'(core_c), 128'(64'h0123_4567_89AB_CDEF));
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests from reset, held for four jobs
    req = 2'b11;
    applyStimulus(2'b01, DIG0, 2'b11, 0, "rr1");
    applyStimulus(2'b10, DIG1, 2'b11, 0, "rr2");
    applyStimulus(2'b01, DIG0, 2'b11, 0, "rr3");
    applyStimulus(2'b10, DIG1, 2'b00, 0, "rr4");

    req = 2'b01;
    applyStimulus(2'b01, DIG0, 2'b00, 0, "single");

    req = 2'b01;
    applyStimulus(2'b01, DIG0, 2'b00, 2, "stability");
    msg0 = MSG0_VEC;

    // Spurious core_end in every non-WAIT state
    spurEnd = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("spur idle busy", 128'(busy), 128'(0));
    checkOutput("spur idle H_left", 128'(core_prev_left), 128'(64'hA));
    checkOutput("spur idle H_right", 128'(core_prev_right), 128'(64'h4));
    req = 2'b10;
    applyStimulus(2'b10, DIG1, 2'b00, 0, "spurious");
    spurEnd = 1'b0;

    // Reset during the second block's WAIT
    req = 2'b01;
    @(negedge clk);
    checkOutput("midrst grant", 128'(grant), 128'(2'b01));
    repeat (7) @(negedge clk);
    checkOutput("midrst busy before", 128'(busy), 128'(1));
    checkOutput("midrst in wait", 128'(core_rst), 128'(0));
    rst = 1'b1;
    #1;
    checkOutput("midrst grant after", 128'(grant), 128'(0));
    checkOutput("midrst busy after", 128'(busy), 128'(0));
    checkOutput("midrst digest after", digest, 128'(0));
    checkOutput("midrst core_rst after", 128'(core_rst), 128'(1));
    checkOutput("midrst H_left after", 128'(core_prev_left), 128'(0));
    req = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b10, DIG1, 2'b00, 0, "post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
